// File: rtl/pkt_route_if.sv
`default_nettype none
// ============================================================================
// Module   : pkt_route_if
// Brief    : Handshake bundle between the routing sequencer and its RX header
//            buffer, destination checker, next-hop selector and TX queue.
// Revision : 1.0
// ============================================================================
interface pkt_route_if #(
    parameter int WORD_WIDTH = 16,
    parameter int HOP_WIDTH  = 8
);
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [WORD_WIDTH-1:0] pkt_dest_id;
    logic [HOP_WIDTH-1:0]  pkt_hops;
    logic                  dst_en;
    logic                  dst_start;
    logic [WORD_WIDTH-1:0] dst_id;
    logic                  dst_done;
    logic                  dst_iam;
    logic                  nh_en;
    logic                  nh_start;
    logic                  nh_done;
    logic [WORD_WIDTH-1:0] nh_id;
    logic                  deliver;
    logic                  fwd_valid;
    logic                  fwd_ready;
    logic [WORD_WIDTH-1:0] fwd_next_hop;
    logic [HOP_WIDTH-1:0]  fwd_hops;
    logic                  drop;
    logic                  err_timeout;

    // Sequencer side
    modport master (
        input  pkt_valid, pkt_dest_id, pkt_hops, dst_done, dst_iam,
               nh_done, nh_id, fwd_ready,
        output pkt_ready, dst_en, dst_start, dst_id, nh_en, nh_start,
               deliver, fwd_valid, fwd_next_hop, fwd_hops, drop, err_timeout
    );

    // Environment side (RX buffer, checker, selector, TX queue)
    modport slave (
        output pkt_valid, pkt_dest_id, pkt_hops, dst_done, dst_iam,
               nh_done, nh_id, fwd_ready,
        input  pkt_ready, dst_en, dst_start, dst_id, nh_en, nh_start,
               deliver, fwd_valid, fwd_next_hop, fwd_hops, drop, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pkt_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pkt_route_sequencer
// Brief    : Per-node routing controller: checks destination, then delivers,
//            drops, or selects a next hop and forwards. Optional watchdog on
//            the wait states is enabled with `define ROUTE_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
module pkt_route_sequencer #(
    parameter int WORD_WIDTH = 16,
    parameter int HOP_WIDTH  = 8,
    parameter int MAX_HOPS   = 16
`ifdef ROUTE_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clock,
    input  logic        rst,
    pkt_route_if.master bus
);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_DST_EN    = 4'd1;
    localparam logic [3:0] c_DST_START = 4'd2;
    localparam logic [3:0] c_DST_WAIT  = 4'd3;
    localparam logic [3:0] c_NH_EN     = 4'd4;
    localparam logic [3:0] c_NH_START  = 4'd5;
    localparam logic [3:0] c_NH_WAIT   = 4'd6;
    localparam logic [3:0] c_FWD       = 4'd7;
    localparam logic [3:0] c_DELIVER   = 4'd8;
    localparam logic [3:0] c_DROP      = 4'd9;

    logic [3:0]            r_state;
    logic [3:0]            w_nxt;
    logic [WORD_WIDTH-1:0] r_dest;
    logic [HOP_WIDTH-1:0]  r_hops;
    logic [HOP_WIDTH-1:0]  r_fwd_hops;
    logic [WORD_WIDTH-1:0] r_nh;
    logic                  r_pkt_ready;
    logic                  r_dst_en;
    logic                  r_dst_start;
    logic                  r_nh_en;
    logic                  r_nh_start;
    logic                  r_deliver;
    logic                  r_fwd_valid;
    logic                  r_drop;
    logic                  w_accept;
    logic                  w_hop_limit;
    logic                  w_timeout;
    logic [HOP_WIDTH-1:0]  w_hops_inc;

    assign w_accept    = (r_state == c_IDLE) && bus.pkt_valid;
    assign w_hop_limit = (32'(r_hops) >= 32'(MAX_HOPS));
    assign w_hops_inc  = (bus.pkt_hops == '1) ? bus.pkt_hops : bus.pkt_hops + 1'b1;

    // A done seen in the same cycle as the watchdog limit wins over the timeout
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            c_IDLE:      if (bus.pkt_valid) w_nxt = c_DST_EN;
            c_DST_EN:    w_nxt = c_DST_START;
            c_DST_START: w_nxt = c_DST_WAIT;
            c_DST_WAIT: begin
                if (bus.dst_done) begin
                    if (bus.dst_iam)  w_nxt = c_DELIVER;
                    else if (w_hop_limit) w_nxt = c_DROP;
                    else              w_nxt = c_NH_EN;
                end else if (w_timeout) begin
                    w_nxt = c_DROP;
                end
            end
            c_NH_EN:     w_nxt = c_NH_START;
            c_NH_START:  w_nxt = c_NH_WAIT;
            c_NH_WAIT: begin
                if (bus.nh_done)     w_nxt = c_FWD;
                else if (w_timeout)  w_nxt = c_DROP;
            end
            c_FWD:       if (bus.fwd_ready) w_nxt = c_IDLE;
            c_DELIVER:   w_nxt = c_IDLE;
            c_DROP:      w_nxt = c_IDLE;
            default:     w_nxt = c_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each is visible exactly
    // while the FSM occupies the corresponding state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_dest      <= '0;
            r_hops      <= '0;
            r_fwd_hops  <= '0;
            r_nh        <= '0;
            r_pkt_ready <= 1'b1;
            r_dst_en    <= 1'b0;
            r_dst_start <= 1'b0;
            r_nh_en     <= 1'b0;
            r_nh_start  <= 1'b0;
            r_deliver   <= 1'b0;
            r_fwd_valid <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            if (w_accept) begin
                r_dest     <= bus.pkt_dest_id;
                r_hops     <= bus.pkt_hops;
                r_fwd_hops <= w_hops_inc;
            end
            if ((r_state == c_NH_WAIT) && bus.nh_done) r_nh <= bus.nh_id;
            r_pkt_ready <= (w_nxt == c_IDLE);
            r_dst_en    <= (w_nxt == c_DST_EN);
            r_dst_start <= (w_nxt == c_DST_START);
            r_nh_en     <= (w_nxt == c_NH_EN);
            r_nh_start  <= (w_nxt == c_NH_START);
            r_deliver   <= (w_nxt == c_DELIVER);
            r_fwd_valid <= (w_nxt == c_FWD);
            r_drop      <= (w_nxt == c_DROP);
        end
    end

`ifdef ROUTE_WATCHDOG_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wd_cnt;
    logic               r_err;
    logic               w_in_wait;
    logic               w_wait_done;

    assign w_in_wait   = (r_state == c_DST_WAIT) || (r_state == c_NH_WAIT);
    assign w_wait_done = ((r_state == c_DST_WAIT) && bus.dst_done) ||
                         ((r_state == c_NH_WAIT)  && bus.nh_done);
    assign w_timeout   = w_in_wait && (r_wd_cnt == c_CNT_LAST);

    // Wait states are never adjacent, so the counter is already zero on entry
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_in_wait) r_wd_cnt <= r_wd_cnt + 1'b1;
            else           r_wd_cnt <= '0;
            if (w_timeout && !w_wait_done) r_err <= 1'b1;
        end
    end

    assign bus.err_timeout = r_err;
`else
    assign w_timeout       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.pkt_ready    = r_pkt_ready;
    assign bus.dst_en       = r_dst_en;
    assign bus.dst_start    = r_dst_start;
    assign bus.dst_id       = r_dest;
    assign bus.nh_en        = r_nh_en;
    assign bus.nh_start     = r_nh_start;
    assign bus.deliver      = r_deliver;
    assign bus.fwd_valid    = r_fwd_valid;
    assign bus.fwd_next_hop = r_nh;
    assign bus.fwd_hops     = r_fwd_hops;
    assign bus.drop         = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pkt_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_route_sequencer
// Brief    : Randomized self-checking bench for pkt_route_sequencer against a
//            per-packet timeline model built from the routing rules.
// Revision : 1.0
// ============================================================================
module tb_pkt_route_sequencer;

    localparam int c_WW       = 16;
    localparam int c_HW       = 8;
    localparam int c_MAXH     = 16;
    localparam int c_MAXH_SAT = 256;
    localparam int c_TIMEOUT  = 64;

    // Observed vector: {ready, dst_en, dst_start, nh_en, nh_start, deliver, fwd_valid, drop, err}
    localparam logic [8:0] c_V_RDY = 9'h100;
    localparam logic [8:0] c_V_DEN = 9'h080;
    localparam logic [8:0] c_V_DST = 9'h040;
    localparam logic [8:0] c_V_NEN = 9'h020;
    localparam logic [8:0] c_V_NST = 9'h010;
    localparam logic [8:0] c_V_DLV = 9'h008;
    localparam logic [8:0] c_V_FWD = 9'h004;
    localparam logic [8:0] c_V_DRP = 9'h002;
    localparam logic [8:0] c_V_ERR = 9'h001;

    logic            clock = 1'b0;
    logic            rst   = 1'b1;
    logic            pkt_valid = 1'b0;
    logic [c_WW-1:0] pkt_dest_id = '0;
    logic [c_HW-1:0] pkt_hops = '0;
    logic            dst_done = 1'b0;
    logic            dst_iam = 1'b0;
    logic            nh_done = 1'b0;
    logic [c_WW-1:0] nh_id = '0;
    logic            fwd_ready = 1'b0;
    logic            exp_err = 1'b0;
    int              n_checks = 0;
    int              n_errors = 0;

    always #5 clock = ~clock;

    pkt_route_if #(.WORD_WIDTH(c_WW), .HOP_WIDTH(c_HW)) bus_a ();
    pkt_route_if #(.WORD_WIDTH(c_WW), .HOP_WIDTH(c_HW)) bus_b ();

    assign bus_a.pkt_valid   = pkt_valid;
    assign bus_a.pkt_dest_id = pkt_dest_id;
    assign bus_a.pkt_hops    = pkt_hops;
    assign bus_a.dst_done    = dst_done;
    assign bus_a.dst_iam     = dst_iam;
    assign bus_a.nh_done     = nh_done;
    assign bus_a.nh_id       = nh_id;
    assign bus_a.fwd_ready   = fwd_ready;
    assign bus_b.pkt_valid   = pkt_valid;
    assign bus_b.pkt_dest_id = pkt_dest_id;
    assign bus_b.pkt_hops    = pkt_hops;
    assign bus_b.dst_done    = dst_done;
    assign bus_b.dst_iam     = dst_iam;
    assign bus_b.nh_done     = nh_done;
    assign bus_b.nh_id       = nh_id;
    assign bus_b.fwd_ready   = fwd_ready;

    pkt_route_sequencer #(.WORD_WIDTH(c_WW), .HOP_WIDTH(c_HW), .MAX_HOPS(c_MAXH)) u_dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_a.master)
    );

    // Hop limit out of reach so that saturation of the hop field can be seen
    pkt_route_sequencer #(.WORD_WIDTH(c_WW), .HOP_WIDTH(c_HW), .MAX_HOPS(c_MAXH_SAT)) u_dut_sat (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_b.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs(input bit sat);
        if (sat)
            return {bus_b.pkt_ready, bus_b.dst_en, bus_b.dst_start, bus_b.nh_en, bus_b.nh_start,
                    bus_b.deliver, bus_b.fwd_valid, bus_b.drop, bus_b.err_timeout};
        return {bus_a.pkt_ready, bus_a.dst_en, bus_a.dst_start, bus_a.nh_en, bus_a.nh_start,
                bus_a.deliver, bus_a.fwd_valid, bus_a.drop, bus_a.err_timeout};
    endfunction

    function automatic logic [c_HW-1:0] hop_inc(input logic [c_HW-1:0] h);
        int v;
        v = int'(h) + 1;
        if (v > (1 << c_HW) - 1) return '1;
        return c_HW'(v);
    endfunction

    // One packet from its accept cycle (index 0) to its outcome cycle.
    // d/e: cycles spent in the checker/selector wait, s: fwd_ready stall cycles.
    task automatic run_pkt(input bit sat, input logic [c_WW-1:0] dest, input logic [c_HW-1:0] hops,
                           input bit iam, input int d, input logic [c_WW-1:0] nhid, input int e,
                           input int s, input bit hold, input bit wd);
        logic [8:0] q[$];
        bit         fwd;
        int         lim;
        lim = sat ? c_MAXH_SAT : c_MAXH;
        fwd = !wd && !iam && (int'(hops) < lim);
        q.push_back(c_V_RDY);
        q.push_back(c_V_DEN);
        q.push_back(c_V_DST);
        if (wd) begin
            repeat (c_TIMEOUT) q.push_back(9'h0);
            q.push_back(c_V_DRP | c_V_ERR);
        end else begin
            repeat (d) q.push_back(9'h0);
            if (iam)       q.push_back(c_V_DLV);
            else if (!fwd) q.push_back(c_V_DRP);
            else begin
                q.push_back(c_V_NEN);
                q.push_back(c_V_NST);
                repeat (e) q.push_back(9'h0);
                repeat (s + 1) q.push_back(c_V_FWD);
            end
        end
        for (int k = 0; k < q.size(); k++) begin
            #1;
            pkt_valid   = (k == 0) || hold;
            pkt_dest_id = (k == 0) ? dest : c_WW'($urandom);
            pkt_hops    = (k == 0) ? hops : c_HW'($urandom);
            dst_done    = !wd && (k == 2 + d);
            dst_iam     = (k == 2 + d) ? iam : 1'($urandom);
            nh_done     = fwd && (k == 4 + d + e);
            nh_id       = (k == 4 + d + e) ? nhid : c_WW'($urandom);
            fwd_ready   = fwd && (k == 5 + d + e + s);
            @(negedge clock);
            chk("strobes", 32'(obs(sat)), 32'(q[k] | (exp_err ? c_V_ERR : 9'h0)));
            if (q[k] == c_V_DST)
                chk("dst_id", 32'(sat ? bus_b.dst_id : bus_a.dst_id), 32'(dest));
            if (q[k] == c_V_FWD) begin
                chk("fwd_next_hop", 32'(sat ? bus_b.fwd_next_hop : bus_a.fwd_next_hop), 32'(nhid));
                chk("fwd_hops", 32'(sat ? bus_b.fwd_hops : bus_a.fwd_hops), 32'(hop_inc(hops)));
            end
            @(posedge clock);
        end
        if (wd) exp_err = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            pkt_valid = 1'b0;
            dst_done  = 1'b0;
            nh_done   = 1'b0;
            fwd_ready = 1'b0;
            @(negedge clock);
            chk("idle", 32'(obs(1'b0)), 32'(c_V_RDY | (exp_err ? c_V_ERR : 9'h0)));
            @(posedge clock);
        end
    endtask

    task automatic pulse_rst();
        #1;
        pkt_valid = 1'b0;
        dst_done  = 1'b0;
        nh_done   = 1'b0;
        fwd_ready = 1'b0;
        rst       = 1'b1;
        #2;
        rst       = 1'b0;
        exp_err   = 1'b0;
        @(posedge clock);
    endtask

    task automatic reset_mid_nh();
        for (int k = 0; k < 6; k++) begin
            #1;
            pkt_valid   = (k == 0);
            pkt_dest_id = 16'h0042;
            pkt_hops    = 8'd2;
            dst_done    = (k == 3);
            dst_iam     = 1'b0;
            nh_done     = 1'b0;
            fwd_ready   = 1'b0;
            @(posedge clock);
        end
        #1;
        chk("nh_wait_quiet", 32'(obs(1'b0)), 32'(exp_err ? c_V_ERR : 9'h0));
        #2;
        rst = 1'b1;
        exp_err = 1'b0;
        #1;
        chk("rst_async", 32'(obs(1'b0)), 32'(c_V_RDY));
        chk("rst_dst_id", 32'(bus_a.dst_id), 32'h0);
        nh_done   = 1'b1;
        nh_id     = 16'h0033;
        fwd_ready = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk("post_rst", 32'(obs(1'b0)), 32'(c_V_RDY));
            chk("post_rst_nh", 32'(bus_a.fwd_next_hop), 32'h0);
        end
        @(posedge clock);
        #1;
        nh_done   = 1'b0;
        fwd_ready = 1'b0;
        @(posedge clock);
    endtask

    initial begin
        #12;
        chk("reset_strobes", 32'(obs(1'b0)), 32'(c_V_RDY));
        chk("reset_fwd_hops", 32'(bus_a.fwd_hops), 32'h0);
        chk("reset_dst_id", 32'(bus_a.dst_id), 32'h0);
        @(negedge clock);
        rst = 1'b0;
        @(posedge clock);

        // local delivery, checker answers one full cycle after start
        run_pkt(1'b0, 16'h0005, 8'd1, 1'b1, 2, 16'h0, 1, 0, 1'b0, 1'b0);
        // forward with a 4-cycle TX stall
        run_pkt(1'b0, 16'h0100, 8'd3, 1'b0, 1, 16'h0012, 2, 4, 1'b0, 1'b0);
        // hop limit boundary
        run_pkt(1'b0, 16'h0200, 8'd16, 1'b0, 3, 16'h0044, 1, 0, 1'b0, 1'b0);
        run_pkt(1'b0, 16'h0201, 8'd15, 1'b0, 1, 16'h0045, 1, 0, 1'b0, 1'b0);
        // valid held through a packet; next header taken on the first idle cycle
        run_pkt(1'b0, 16'h0300, 8'd4, 1'b1, 1, 16'h0, 1, 0, 1'b1, 1'b0);
        run_pkt(1'b0, 16'h0301, 8'd5, 1'b0, 2, 16'h0099, 3, 1, 1'b1, 1'b0);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            logic [c_HW-1:0] h;
            case ($urandom_range(0, 3))
                0:       h = c_HW'($urandom_range(0, 14));
                1:       h = 8'd15;
                2:       h = 8'd16;
                default: h = c_HW'($urandom_range(17, 255));
            endcase
            run_pkt(1'b0, c_WW'($urandom), h, 1'($urandom), $urandom_range(1, 5),
                    c_WW'($urandom), $urandom_range(1, 5), $urandom_range(0, 5),
                    ($urandom_range(0, 3) == 0), 1'b0);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);

        reset_mid_nh();
        idle(2);

        // hop saturation on the instance whose limit cannot be reached
        pulse_rst();
        run_pkt(1'b1, 16'h0400, 8'hFF, 1'b0, 2, 16'h0077, 1, 1, 1'b0, 1'b0);
        run_pkt(1'b1, 16'h0401, 8'hFE, 1'b0, 1, 16'h0078, 2, 0, 1'b0, 1'b0);
        idle(1);

`ifdef ROUTE_WATCHDOG_EN
        run_pkt(1'b0, 16'h0500, 8'd2, 1'b0, 1, 16'h0, 1, 0, 1'b0, 1'b1);
        idle(1);
        run_pkt(1'b0, 16'h0501, 8'd2, 1'b1, 2, 16'h0, 1, 0, 1'b0, 1'b0);
        run_pkt(1'b0, 16'h0502, 8'd2, 1'b0, 1, 16'h0055, 1, 1, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
